// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes and NZCV bit positions.
// Imported by the decode-side control unit and by the execute stage.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_PASS_B = 4'b0000,
        OP_ADD    = 4'b0010,
        OP_SUB    = 4'b0011,
        OP_CBZ    = 4'b0100
    } alu_op_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_execute_stage_if.sv
// Execute-stage bundle: decoded operands and controls in, EX/MEM results and flags out.
interface alu_execute_stage_if #(parameter int WIDTH = 64);

    logic             ALU_on;
    logic [3:0]       ALU_cntrl;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             set_flags;
    logic             stall;
    logic             flush;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             result_valid;
    logic             illegal_op;
    logic [3:0]       flags;
    logic [3:0]       flags_fwd;

    modport master (
        output ALU_on, ALU_cntrl, A, B, set_flags, stall, flush,
        input  result, zero, result_valid, illegal_op, flags, flags_fwd
    );

    modport slave (
        input  ALU_on, ALU_cntrl, A, B, set_flags, stall, flush,
        output result, zero, result_valid, illegal_op, flags, flags_fwd
    );

endinterface

// File: rtl/alu_core.sv
// Combinational ALU: (a, b, op) -> (result, nzcv, legal). Illegal codes yield result 0.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       nzcv,
    output logic             legal
);

    logic [WIDTH:0] sum_ext;
    logic [WIDTH:0] diff_ext;

    // Subtraction as A + ~B + 1 so the carry-out is ARM's "no borrow" C flag.
    assign sum_ext  = {1'b0, a} + {1'b0, b};
    assign diff_ext = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        // NOTE: every output gets a default before the case, so no path can infer a latch.
        result = '0;
        nzcv   = '0;
        legal  = 1'b0;
        case (op)
            OP_PASS_B, OP_CBZ: begin
                result = b;
                legal  = 1'b1;
            end
            OP_ADD: begin
                result       = sum_ext[WIDTH-1:0];
                nzcv[FLAG_C] = sum_ext[WIDTH];
                nzcv[FLAG_V] = (a[WIDTH-1] == b[WIDTH-1]) && (sum_ext[WIDTH-1] != a[WIDTH-1]);
                legal        = 1'b1;
            end
            OP_SUB: begin
                result       = diff_ext[WIDTH-1:0];
                nzcv[FLAG_C] = diff_ext[WIDTH];
                nzcv[FLAG_V] = (a[WIDTH-1] != b[WIDTH-1]) && (diff_ext[WIDTH-1] != a[WIDTH-1]);
                legal        = 1'b1;
            end
            default: ;
        endcase
        nzcv[FLAG_N] = result[WIDTH-1];
        nzcv[FLAG_Z] = (result == '0);
    end

endmodule

// File: rtl/alu_execute_stage.sv
// EX stage: alu_core plus the EX/MEM result register, NZCV register and stall/flush control.
module alu_execute_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 reset_n,
    alu_execute_stage_if.slave   bus
);

    logic [WIDTH-1:0] core_result;
    logic [3:0]       core_nzcv;
    logic             core_legal;

    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             valid_q;
    logic             illegal_q;
    logic [3:0]       flags_q;
    logic             flag_en;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .a      (bus.A),
        .b      (bus.B),
        .op     (bus.ALU_cntrl),
        .result (core_result),
        .nzcv   (core_nzcv),
        .legal  (core_legal)
    );

    assign flag_en = bus.ALU_on && bus.set_flags && core_legal && !bus.stall && !bus.flush;

    // Flush outranks stall; a bubble (ALU_on low) loads the same values as a flush.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: non-blocking assignments for all registered state, so every flop samples pre-edge values.
        if (!reset_n) begin
            result_q  <= '0;
            zero_q    <= 1'b1;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else if (bus.flush || (!bus.stall && !bus.ALU_on)) begin
            result_q  <= '0;
            zero_q    <= 1'b1;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else if (!bus.stall) begin
            result_q  <= core_result;
            zero_q    <= (core_result == '0);
            valid_q   <= 1'b1;
            illegal_q <= !core_legal;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flags_q <= 4'b0000;
        end else if (flag_en) begin
            flags_q <= core_nzcv;
        end
    end

    assign bus.result       = result_q;
    assign bus.zero         = zero_q;
    assign bus.result_valid = valid_q;
    assign bus.illegal_op   = illegal_q;
    assign bus.flags        = flags_q;
    assign bus.flags_fwd    = flag_en ? core_nzcv : flags_q;

endmodule

// File: tb/tb_alu_execute_stage.sv
// Scoreboard bench for alu_execute_stage: directed vectors push expected EX/MEM values,
// a monitor pops and compares one entry per clock edge.
module tb_alu_execute_stage;

    localparam int W = 64;

    typedef struct {
        string          name;
        logic [W-1:0]   result;
        logic           zero;
        logic           valid;
        logic           illegal;
        logic [3:0]     flags;
    } exp_t;

    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_fail;
    exp_t sb_q[$];

    alu_execute_stage_if #(.WIDTH(W)) bus ();

    alu_execute_stage #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus, check the combinational flags_fwd, queue the registered expectation.
    task automatic issue(input string name, input logic on, input logic [3:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sf, input logic st, input logic fl,
                         input logic [W-1:0] e_res, input logic e_zero, input logic e_valid,
                         input logic e_ill, input logic [3:0] e_flags, input logic [3:0] e_fwd);
        exp_t e;
        @(negedge clk);
        bus.ALU_on    = on;
        bus.ALU_cntrl = op;
        bus.A         = a;
        bus.B         = b;
        bus.set_flags = sf;
        bus.stall     = st;
        bus.flush     = fl;
        #1;
        check({name, ".flags_fwd"}, W'(bus.flags_fwd), W'(e_fwd));
        e.name    = name;
        e.result  = e_res;
        e.zero    = e_zero;
        e.valid   = e_valid;
        e.illegal = e_ill;
        e.flags   = e_flags;
        sb_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check({e.name, ".result"},  bus.result,            e.result);
                check({e.name, ".zero"},    W'(bus.zero),          W'(e.zero));
                check({e.name, ".valid"},   W'(bus.result_valid),  W'(e.valid));
                check({e.name, ".illegal"}, W'(bus.illegal_op),    W'(e.illegal));
                check({e.name, ".flags"},   W'(bus.flags),         W'(e.flags));
            end
        end
    end

    initial begin : stimulus
        localparam logic [W-1:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
        localparam logic [W-1:0] MINN = 64'h8000_0000_0000_0000;
        localparam logic [W-1:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
        n_checks = 0;
        n_fail   = 0;
        reset_n  = 1'b0;
        bus.ALU_on = 1'b0; bus.ALU_cntrl = 4'b0000; bus.A = '0; bus.B = '0;
        bus.set_flags = 1'b0; bus.stall = 1'b0; bus.flush = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("rst.result",    bus.result,            '0);
        check("rst.zero",      W'(bus.zero),          W'(1'b1));
        check("rst.valid",     W'(bus.result_valid),  W'(1'b0));
        check("rst.illegal",   W'(bus.illegal_op),    W'(1'b0));
        check("rst.flags",     W'(bus.flags),         W'(4'b0000));
        check("rst.flags_fwd", W'(bus.flags_fwd),     W'(4'b0000));
        @(negedge clk);
        reset_n = 1'b1;

        //     name          on  op       A        B     sf st fl  result    z  v  il flags    fwd
        issue("adds_ovf",    1, 4'b0010, MAXP,    1,     1, 0, 0, MINN,     0, 1, 0, 4'b1001, 4'b1001);
        issue("subs_eq",     1, 4'b0011, 5,       5,     1, 0, 0, 0,        1, 1, 0, 4'b0110, 4'b0110);
        issue("subs_neg",    1, 4'b0011, 0,       1,     1, 0, 0, ONES,     0, 1, 0, 4'b1000, 4'b1000);
        issue("ldur_add",    1, 4'b0010, 'h1000,  8,     0, 0, 0, 'h1008,   0, 1, 0, 4'b1000, 4'b1000);
        issue("subs_pos",    1, 4'b0011, 10,      3,     1, 0, 0, 7,        0, 1, 0, 4'b0010, 4'b0010);
        for (int i = 0; i < 3; i++)
            issue("stall",   1, 4'b0010, MAXP,    1,     1, 1, 0, 7,        0, 1, 0, 4'b0010, 4'b0010);
        issue("stall_flush", 1, 4'b0010, MAXP,    1,     1, 1, 1, 0,        1, 0, 0, 4'b0010, 4'b0010);
        issue("illegal",     1, 4'b1111, 3,       4,     1, 0, 0, 0,        1, 1, 1, 4'b0010, 4'b0010);
        issue("bubble",      0, 4'b0010, 1,       1,     1, 0, 0, 0,        1, 0, 0, 4'b0010, 4'b0010);
        issue("pass_b_s",    1, 4'b0000, 9,       MINN,  1, 0, 0, MINN,     0, 1, 0, 4'b1000, 4'b1000);
        issue("cbz_zero",    1, 4'b0100, 6,       0,     0, 0, 0, 0,        1, 1, 0, 4'b1000, 4'b1000);
        issue("adds_wrap",   1, 4'b0010, ONES,    1,     1, 0, 0, 0,        1, 1, 0, 4'b0110, 4'b0110);
        issue("adds_ovf2",   1, 4'b0010, MAXP,    1,     1, 0, 0, MINN,     0, 1, 0, 4'b1001, 4'b1001);
        issue("stall_hold",  1, 4'b0011, 5,       5,     1, 1, 0, MINN,     0, 1, 0, 4'b1001, 4'b1001);

        // Reset between edges while the stall is still asserted.
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("arst.result",    bus.result,           '0);
        check("arst.zero",      W'(bus.zero),         W'(1'b1));
        check("arst.valid",     W'(bus.result_valid), W'(1'b0));
        check("arst.illegal",   W'(bus.illegal_op),   W'(1'b0));
        check("arst.flags",     W'(bus.flags),        W'(4'b0000));
        check("arst.flags_fwd", W'(bus.flags_fwd),    W'(4'b0000));
        @(negedge clk);
        reset_n = 1'b1;

        issue("post_rst_add",  1, 4'b0010, 2,       3,     0, 0, 0, 5,        0, 1, 0, 4'b0000, 4'b0000);
        issue("idle",          0, 4'b0000, 0,       0,     0, 0, 0, 0,        1, 0, 0, 4'b0000, 4'b0000);

        for (int i = 0; i < 5 && sb_q.size() != 0; i++) @(posedge clk);
        #2;
        check("scoreboard_drained", W'(sb_q.size()), '0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_execute_stage.md
# alu_execute_stage

Execute-stage datapath of the 5-stage pipelined ARM CPU: the consumer of the 4-bit ALU control code produced during decode. It performs the selected operation on two operands and registers the result and zero indication into the EX/MEM boundary. It holds the architectural NZCV flag register, updated only by flag-setting instructions (ADDS, SUBS). It honours pipeline stall and flush, and exposes same-cycle next flags for conditional-branch resolution.

## Interface
- WIDTH, 64, operand/result width in bits

- clk  input  1  pipeline clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- ALU_on  input  1  EX instruction uses the ALU; low = bubble
- ALU_cntrl  input  4  operation code (see Operation)
- A  input  WIDTH  operand A (Rn)
- B  input  WIDTH  operand B (Rm, immediate, or address offset)
- set_flags  input  1  instruction writes NZCV (ADDS/SUBS)
- stall  input  1  hold all registered state
- flush  input  1  replace the EX instruction with a bubble
- result  output  WIDTH  registered ALU result
- zero  output  1  registered (result == 0)
- result_valid  output  1  registered; result/zero belong to a real instruction
- illegal_op  output  1  registered; ALU_on with an unsupported code
- flags  output  4  architectural NZCV register {N,Z,C,V}
- flags_fwd  output  4  combinational value NZCV will hold after this edge

## Operation
- Codes: 4'b0000 PASS_B (BL), 4'b0010 ADD (ADDI/ADDS/LDUR/STUR), 4'b0011 SUB (SUBS), 4'b0100 PASS_B with zero test (CBZ); every other code is illegal.
- ADD: sum = A + B, WIDTH-bit wrap; C = carry-out of bit WIDTH-1; V = (A[msb]==B[msb]) && (sum[msb]!=A[msb]).
- SUB: A + ~B + 1; C = carry-out (1 means no borrow, ARM convention); V = (A[msb]!=B[msb]) && (diff[msb]!=A[msb]).
- PASS_B: result = B; with set_flags, N/Z come from the result and C = V = 0.
- Illegal code with ALU_on: result = 0, illegal_op = 1, result_valid = 1, flags unchanged.
- ALU_on = 0: result_valid = 0, result = 0, zero = 1, illegal_op = 0, flags unchanged; set_flags is ignored.
- Flag update enable: ALU_on && set_flags && legal code && !stall && !flush.
- flags_fwd = next NZCV when the enable is true, else the current flags.

## Timing
- Reset (asynchronous assert, synchronous-edge deassert):
  - result = 0, zero = 1, result_valid = 0, illegal_op = 0, flags = 4'b0000.
- Latency: 1 cycle. Inputs sampled at edge n appear on the registered outputs after edge n.
- Priority per edge, high to low: reset, flush, stall, normal load.
  - flush: load the bubble values and leave flags unchanged, even if stall is also high.
  - stall without flush: all registered outputs and flags hold; flags_fwd = flags.
- Back-to-back flag setters: the second instruction observes nothing from the first; operands come via forwarding, not from this block. Flags chain edge by edge.
- Reset asserted mid-stall or mid-operation: all state clears immediately, without a clock edge.
- No combinational path from inputs to registered outputs. flags_fwd is the only combinational output.

## Structure
- Shared package alu_pkg:
  - enum alu_op_t for the four legal 4-bit codes
  - localparam indices FLAG_N = 3, FLAG_Z = 2, FLAG_C = 1, FLAG_V = 0
  - this package is also imported by the decode-side control unit
- Sub-module alu_core: purely combinational (A, B, op) -> (result, nzcv, legal).
- alu_execute_stage wraps alu_core with the EX/MEM register, flag register, and stall/flush logic.

## Test plan
- ADDS: A = 0x7FFF_FFFF_FFFF_FFFF, B = 1, set_flags → next cycle result = 0x8000_0000_0000_0000, flags = 4'b1001 (N, V). flags_fwd shows 4'b1001 in the issue cycle.
- SUBS: A = 5, B = 5 → result = 0, zero = 1, flags = 4'b0110 (Z, C). Then A = 0, B = 1 → result = all ones, flags = 4'b1000.
- ADD without set_flags (LDUR): A = 0x1000, B = 8 → result = 0x1008, result_valid = 1, flags unchanged from the prior test.
- Stall and flush: a SUBS is presented, then stall held 3 cycles with new inputs → outputs and flags frozen. Then stall and flush together → result_valid = 0, zero = 1, flags still frozen.
- Illegal code and bubble: ALU_cntrl = 4'b1111 with ALU_on = 1 → illegal_op = 1, result = 0, flags unchanged. ALU_on = 0 with set_flags = 1 → result_valid = 0, flags unchanged.
- Asynchronous reset: assert reset_n low between edges, while flags = 4'b1001 and a stall is active → all outputs return to reset values immediately. First post-reset ADD (2 + 3) → result = 5.
